score_tracker: RTL and testbench

Game-score source feeding the level stage. Runs a START/RUN/OVER game FSM, divides clk into score ticks, and keeps the running score in both binary and 4-digit BCD. The binary score drives the level computation, `running` drives its enable, and the BCD digits go to the HEX score display. It also holds a session high score that only reset clears.

---
 rtl/score_tracker.sv | 121 ++++++++++++
 tb/tb_score_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/score_tracker.sv
// Game score source: START/RUN/OVER FSM, tick prescaler, binary + BCD score
// and a session high score that survives restarts but not reset.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | after reset, waiting for the first start pulse
// S_RUN  | game in progress, score advances on each prescaler tick
// S_OVER | crash seen, final score and high score held until next start
module score_tracker #(
  parameter int unsigned TICK_DIV  = 5000000,
  parameter int unsigned SCORE_MAX = 9999
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        enable,
  input  logic        collision,
  output logic [15:0] score,
  output logic [15:0] score_bcd,
  output logic [15:0] high_score,
  output logic        running,
  output logic        game_over,
  output logic        new_high
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  state_t          state_q;
  logic [PW-1:0]   presc_q;
  logic [15:0]     score_q;
  logic [15:0]     bcd_q;
  logic [15:0]     high_q;
  logic            running_q;
  logic            game_over_q;
  logic            new_high_q;

  logic            tick;
  logic            carry;
  logic [15:0]     bcd_d;

  always_comb begin
    tick  = (state_q == S_RUN) && enable && !collision &&
            (presc_q == PW'(TICK_DIV - 1));
    bcd_d = bcd_q;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_d[4*i +: 4] = 4'd0;
        end else begin
          bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      score_q     <= '0;
      bcd_q       <= '0;
      high_q      <= '0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
      new_high_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_OVER: begin
          // Collision is ignored here; it only matters once in RUN.
          if (start) begin
            state_q     <= S_RUN;
            running_q   <= 1'b1;
            game_over_q <= 1'b0;
            new_high_q  <= 1'b0;
            presc_q     <= '0;
            score_q     <= '0;
            bcd_q       <= '0;
          end
        end
        S_RUN: begin
          if (collision) begin
            state_q     <= S_OVER;
            running_q   <= 1'b0;
            game_over_q <= 1'b1;
            if (score_q > high_q) begin
              high_q     <= score_q;
              new_high_q <= 1'b1;
            end else begin
              new_high_q <= 1'b0;
            end
          end else if (tick) begin
            presc_q <= '0;
            if (score_q < 16'(SCORE_MAX)) begin
              score_q <= score_q + 16'd1;
              bcd_q   <= bcd_d;
            end
          end else if (enable) begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: begin
          state_q     <= S_IDLE;
          running_q   <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign score      = score_q;
  assign score_bcd  = bcd_q;
  assign high_score = high_q;
  assign running    = running_q;
  assign game_over  = game_over_q;
  assign new_high   = new_high_q;

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: two instances (TICK_DIV=4/SCORE_MAX=9999 and
// TICK_DIV=2/SCORE_MAX=12) share stimulus and are checked against a game model.
module tb_score_tracker;

  logic clk = 1'b0;
  logic resetn, start, enable, collision;

  logic [15:0] score0, bcd0, high0, score1, bcd1, high1;
  logic        run0, over0, nh0, run1, over1, nh1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_tracker #(.TICK_DIV(4), .SCORE_MAX(9999)) dut (
    .clk(clk), .resetn(resetn), .start(start), .enable(enable),
    .collision(collision), .score(score0), .score_bcd(bcd0),
    .high_score(high0), .running(run0), .game_over(over0), .new_high(nh0)
  );

  score_tracker #(.TICK_DIV(2), .SCORE_MAX(12)) dut2 (
    .clk(clk), .resetn(resetn), .start(start), .enable(enable),
    .collision(collision), .score(score1), .score_bcd(bcd1),
    .high_score(high1), .running(run1), .game_over(over1), .new_high(nh1)
  );

  // Model: mode 0 = waiting, 1 = playing, 2 = crashed.
  int td[2] = '{4, 2};
  int sm[2] = '{9999, 12};
  int m_mode[2], m_cnt[2], m_sc[2], m_hi[2], m_nh[2];

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
           ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_sc[i] = 0; m_hi[i] = 0; m_nh[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_mode[i] == 1) begin
          if (collision) begin
            m_mode[i] = 2;
            m_nh[i]   = (m_sc[i] > m_hi[i]) ? 1 : 0;
            if (m_sc[i] > m_hi[i]) m_hi[i] = m_sc[i];
          end else if (enable) begin
            m_cnt[i]++;
            if (m_cnt[i] == td[i]) begin
              m_cnt[i] = 0;
              if (m_sc[i] < sm[i]) m_sc[i]++;
            end
          end
        end else if (start) begin
          m_mode[i] = 1; m_cnt[i] = 0; m_sc[i] = 0; m_nh[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("score0", score0, m_sc[0]);
    chk("bcd0", bcd0, to_bcd(m_sc[0]));
    chk("high0", high0, m_hi[0]);
    chk("running0", run0, m_mode[0] == 1);
    chk("game_over0", over0, m_mode[0] == 2);
    chk("new_high0", nh0, m_nh[0]);
    chk("score1", score1, m_sc[1]);
    chk("bcd1", bcd1, to_bcd(m_sc[1]));
    chk("high1", high1, m_hi[1]);
    chk("running1", run1, m_mode[1] == 1);
    chk("game_over1", over1, m_mode[1] == 2);
    chk("new_high1", nh1, m_nh[1]);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic crash();
    collision = 1'b1;
    cyc();
    collision = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; enable = 1'b0; collision = 1'b0;
    cyc(2);
    chk("rst_score", score0, 0);
    chk("rst_running", run0, 0);
    resetn = 1'b1;
    cyc();

    // Basic counting and pause
    enable = 1'b1;
    start_game();
    chk("start_running", run0, 1);
    chk("start_score", score0, 0);
    cyc(4);
    chk("first_tick", score0, 1);
    chk("model_first_tick", m_sc[0], 1);
    cyc(16);
    chk("score5", score0, 5);
    chk("bcd5", bcd0, 16'h0005);
    cyc(2);
    enable = 1'b0;
    cyc(10);
    chk("paused", score0, 5);
    enable = 1'b1;
    cyc();
    chk("resume_1", score0, 5);
    cyc();
    chk("resume_2", score0, 6);

    // BCD carries
    cyc(93 * 4);
    chk("s99", score0, 99);
    chk("bcd99", bcd0, 16'h0099);
    cyc(4);
    chk("s100", score0, 100);
    chk("bcd100", bcd0, 16'h0100);
    cyc(899 * 4);
    chk("s999", score0, 999);
    chk("bcd999", bcd0, 16'h0999);
    cyc(4);
    chk("s1000", score0, 1000);
    chk("bcd1000", bcd0, 16'h1000);
    chk("sat_score", score1, 12);
    chk("sat_bcd", bcd1, 16'h0012);

    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();

    // High-score sequence
    start_game();
    cyc(28);
    crash();
    chk("g1_over", over0, 1);
    chk("g1_high", high0, 7);
    chk("g1_nh", nh0, 1);
    chk("model_g1_high", m_hi[0], 7);
    start_game();
    chk("g2_nh_cleared", nh0, 0);
    cyc(28);
    crash();
    chk("g2_high", high0, 7);
    chk("g2_nh", nh0, 0);
    start_game();
    cyc(36);
    crash();
    chk("g3_high", high0, 9);
    chk("g3_nh", nh0, 1);

    // Collision on a tick cycle
    start_game();
    cyc(15);
    crash();
    chk("coltick_score", score0, 3);
    chk("coltick_over", over0, 1);

    // Asynchronous reset mid-run
    start_game();
    cyc(5);
    #2 resetn = 1'b0;
    #1;
    chk("arst_score", score0, 0);
    chk("arst_bcd", bcd0, 0);
    chk("arst_high", high0, 0);
    chk("arst_running", run0, 0);
    chk("arst_over", over0, 0);
    chk("arst_nh", nh0, 0);
    cyc();
    resetn = 1'b1;
    cyc();

    // Random play
    for (int k = 0; k < 4000; k++) begin
      start     = ($urandom_range(0, 39) == 0);
      collision = ($urandom_range(0, 29) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      cyc();
    end
    start = 1'b0; collision = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
